// File: rtl/mem_writeback_buffer_if.sv
// Cache-facing bus of the write-back buffer: eviction push, fill read, drain control and status.
// Handshakes: a push happens on an edge with wb_valid && wb_ready; a read is accepted on an edge with rd_req && rd_ready.
interface mem_writeback_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_ready;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              mem_hold;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              dbg_state;

  modport master (
    output wb_valid, wb_addr, wb_data, rd_req, rd_addr, mem_hold,
    input  wb_ready, rd_ready, rd_valid, rd_data, count, empty, dbg_state
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data, rd_req, rd_addr, mem_hold,
    output wb_ready, rd_ready, rd_valid, rd_data, count, empty, dbg_state
  );
endinterface

// File: rtl/mem_writeback_buffer.sv
// Write FIFO of dirty-line evictions draining into a single-port RAM, with fill reads
// that forward the newest still-queued data for their address.
module mem_writeback_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  mem_writeback_buffer_if.slave   bus
);
  localparam int PTR_W     = $clog2(DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int MEM_WORDS = 1 << ADDR_W;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_q_addr [DEPTH];
  logic [DATA_W-1:0] r_q_data [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_mem [MEM_WORDS];
  logic [DATA_W-1:0] r_rd_data;

  logic              w_rd_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_fwd_hit;
  logic [DATA_W-1:0] w_fwd_data;
  logic [PTR_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_rd_src;

  assign bus.wb_ready  = (r_count < CNT_W'(DEPTH));
  assign bus.rd_ready  = (r_state == S_IDLE);
  assign bus.rd_valid  = (r_state == S_RESP);
  assign bus.rd_data   = r_rd_data;
  assign bus.count     = r_count;
  assign bus.empty     = (r_count == '0);
  assign bus.dbg_state = r_state;

  assign w_push = bus.wb_valid && bus.wb_ready;
  // Single RAM port: an accepted read takes it, so the drain waits a cycle.
  assign w_pop  = (r_count != '0) && !bus.mem_hold && !w_rd_accept;

  always_comb begin
    w_state_nxt = r_state;
    w_rd_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.rd_req) begin
          w_rd_accept = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Scan head to tail so the last hit is the newest queued write.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    w_idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_rptr + PTR_W'(k);
      if ((CNT_W'(k) < r_count) && (r_q_addr[w_idx] == bus.rd_addr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_q_data[w_idx];
      end
    end
  end

  always_comb begin
    w_rd_src = r_mem[bus.rd_addr];
    if (w_push && (bus.wb_addr == bus.rd_addr)) begin
      w_rd_src = bus.wb_data;
    end else if (w_fwd_hit) begin
      w_rd_src = w_fwd_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_rd_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_rd_accept) begin
        r_rd_data <= w_rd_src;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_addr[r_wptr] <= bus.wb_addr;
      r_q_data[r_wptr] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_pop) begin
      r_mem[r_q_addr[r_rptr]] <= r_q_data[r_rptr];
    end
  end
endmodule

// File: tb/tb_mem_writeback_buffer.sv
// Bench for mem_writeback_buffer: vector table, directed corner sequences and random
// traffic checked against a queue-and-array reference model.
module tb_mem_writeback_buffer;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;
  localparam int WORDS  = 1 << ADDR_W;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef struct {
    bit                wbv;
    logic [ADDR_W-1:0] wba;
    logic [DATA_W-1:0] wbd;
    bit                rdr;
    logic [ADDR_W-1:0] rda;
    bit                hold;
    int                exp_count;
    bit                exp_rv;
    logic [DATA_W-1:0] exp_rd;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_writeback_buffer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_writeback_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model
  entry_t            m_q[$];
  logic [DATA_W-1:0] m_mem [WORDS];
  bit                m_resp;
  logic [DATA_W-1:0] exp_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    for (int i = 0; i < WORDS; i++) m_mem[i] = '0;
    m_resp = 1'b0;
  endtask

  task automatic drive(input bit wbv, input logic [ADDR_W-1:0] wba, input logic [DATA_W-1:0] wbd,
                       input bit rdr, input logic [ADDR_W-1:0] rda, input bit hold);
    bus.wb_valid = wbv;
    bus.wb_addr  = wba;
    bus.wb_data  = wbd;
    bus.rd_req   = rdr;
    bus.rd_addr  = rda;
    bus.mem_hold = hold;
  endtask

  // One clock: drive at negedge, advance model, compare just after the rising edge.
  task automatic step(input bit wbv, input logic [ADDR_W-1:0] wba, input logic [DATA_W-1:0] wbd,
                      input bit rdr, input logic [ADDR_W-1:0] rda, input bit hold);
    bit                accept, push, pop;
    logic [DATA_W-1:0] d;
    entry_t            e;
    @(negedge clk);
    drive(wbv, wba, wbd, rdr, rda, hold);
    accept = !m_resp && rdr;
    push   = wbv && (m_q.size() < DEPTH);
    pop    = (m_q.size() > 0) && !hold && !accept;
    if (accept) begin
      d = m_mem[rda];
      foreach (m_q[i]) if (m_q[i].addr == rda) d = m_q[i].data;
      if (push && wba == rda) d = wbd;
      exp_q.push_back(d);
    end
    if (pop) begin
      e = m_q.pop_front();
      m_mem[e.addr] = e.data;
    end
    if (push) m_q.push_back(entry_t'{addr: wba, data: wbd});
    m_resp = accept;
    @(posedge clk);
    #1;
    check("count",    32'(bus.count), m_q.size());
    check("empty",    32'(bus.empty), 32'(m_q.size() == 0));
    check("wb_ready", 32'(bus.wb_ready), 32'(m_q.size() < DEPTH));
    check("rd_ready", 32'(bus.rd_ready), 32'(!m_resp));
    check("rd_valid", 32'(bus.rd_valid), 32'(m_resp));
    if (m_resp) begin
      if (exp_q.size() == 0) check("exp_q_underflow", 32'(exp_q.size()), 1);
      else                   check("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic idle(input bit hold);
    step(1'b0, '0, '0, 1'b0, '0, hold);
  endtask

  vec_t tbl[8];

  initial begin
    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_count",    32'(bus.count), 0);
    check("rst_empty",    32'(bus.empty), 1);
    check("rst_wb_ready", 32'(bus.wb_ready), 1);
    check("rst_rd_ready", 32'(bus.rd_ready), 1);
    check("rst_rd_valid", 32'(bus.rd_valid), 0);
    check("rst_rd_data",  32'(bus.rd_data), 0);
    @(negedge clk);
    reset = 1'b1;

    // Reset read, simple push/drain/read, same-cycle push forward
    tbl[0] = '{0, 6'h00, 8'h00, 1, 6'h15, 0, 0, 1, 8'h00};
    tbl[1] = '{0, 6'h00, 8'h00, 0, 6'h00, 0, 0, 0, 8'h00};
    tbl[2] = '{1, 6'h0A, 8'h5C, 0, 6'h00, 0, 1, 0, 8'h00};
    tbl[3] = '{0, 6'h00, 8'h00, 0, 6'h00, 0, 0, 0, 8'h00};
    tbl[4] = '{0, 6'h00, 8'h00, 1, 6'h0A, 0, 0, 1, 8'h5C};
    tbl[5] = '{0, 6'h00, 8'h00, 0, 6'h00, 0, 0, 0, 8'h00};
    tbl[6] = '{1, 6'h30, 8'h77, 1, 6'h30, 0, 1, 1, 8'h77};
    tbl[7] = '{0, 6'h00, 8'h00, 0, 6'h00, 0, 0, 0, 8'h00};
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].wbv, tbl[i].wba, tbl[i].wbd, tbl[i].rdr, tbl[i].rda, tbl[i].hold);
      check($sformatf("tbl%0d_count", i), 32'(bus.count), tbl[i].exp_count);
      check($sformatf("tbl%0d_rd_valid", i), 32'(bus.rd_valid), 32'(tbl[i].exp_rv));
      if (tbl[i].exp_rv) check($sformatf("tbl%0d_rd_data", i), 32'(bus.rd_data), 32'(tbl[i].exp_rd));
    end

    // Fill under hold, stalled fifth push, then drain
    for (int a = 1; a <= 4; a++) step(1'b1, ADDR_W'(a), DATA_W'(8'hA0 + a), 1'b0, '0, 1'b1);
    check("full_count", 32'(bus.count), 4);
    check("full_wb_ready", 32'(bus.wb_ready), 0);
    repeat (2) step(1'b1, 6'h05, 8'hA5, 1'b0, '0, 1'b1);
    check("stall_count", 32'(bus.count), 4);
    step(1'b1, 6'h05, 8'hA5, 1'b0, '0, 1'b0);
    check("release_pop_only", 32'(bus.count), 3);
    step(1'b1, 6'h05, 8'hA5, 1'b0, '0, 1'b0);
    check("push_and_pop", 32'(bus.count), 3);
    repeat (3) idle(1'b0);
    check("drained", 32'(bus.count), 0);
    for (int a = 1; a <= 5; a++) begin
      step(1'b0, '0, '0, 1'b1, ADDR_W'(a), 1'b0);
      check($sformatf("ram_%0h", a), 32'(bus.rd_data), 32'(8'hA0 + a));
      idle(1'b0);
    end

    // Newest-entry forwarding, then the same value from RAM
    step(1'b1, 6'h21, 8'h11, 1'b0, '0, 1'b1);
    step(1'b1, 6'h21, 8'h22, 1'b0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1, 6'h21, 1'b1);
    check("fwd_newest", 32'(bus.rd_data), 32'h22);
    idle(1'b1);
    repeat (2) idle(1'b0);
    check("fwd_drained", 32'(bus.count), 0);
    step(1'b0, '0, '0, 1'b1, 6'h21, 1'b0);
    check("ram_newest", 32'(bus.rd_data), 32'h22);
    idle(1'b0);

    // Asynchronous reset mid-cycle while in RESP with entries queued
    for (int a = 0; a < 3; a++) step(1'b1, ADDR_W'(6'h31 + a), DATA_W'(8'h91 + a), 1'b0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1, 6'h31, 1'b1);
    check("pre_rst_count", 32'(bus.count), 3);
    check("pre_rst_rd_valid", 32'(bus.rd_valid), 1);
    #2 reset = 1'b0;
    #1;
    check("arst_rd_valid", 32'(bus.rd_valid), 0);
    check("arst_count", 32'(bus.count), 0);
    check("arst_empty", 32'(bus.empty), 1);
    check("arst_wb_ready", 32'(bus.wb_ready), 1);
    check("arst_rd_ready", 32'(bus.rd_ready), 1);
    model_reset();
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, '0, '0, 1'b1, 6'h31, 1'b0);
    check("post_rst_31", 32'(bus.rd_data), 0);
    idle(1'b0);
    step(1'b0, '0, '0, 1'b1, 6'h01, 1'b0);
    check("post_rst_01", 32'(bus.rd_data), 0);
    idle(1'b0);

    // Random traffic on a narrow address window to provoke forwarding and same-address drains
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 9) < 6, ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom),
           $urandom_range(0, 1) == 1, ADDR_W'($urandom_range(0, 7)), $urandom_range(0, 9) < 3);
    end
    repeat (DEPTH + 1) idle(1'b0);
    for (int a = 0; a < WORDS; a++) begin
      step(1'b0, '0, '0, 1'b1, ADDR_W'(a), 1'b0);
      idle(1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
